// File: rtl/broadcast_queue.sv
// broadcast_queue
// Collects completed results from NUM_FU functional units, buffers them in a
// DEPTH-entry FIFO and broadcasts one entry per cycle on the common data bus
// (CDB) with a valid/ready handshake toward the rename/ROB stage.
//
// Each FU raises fu_done for one cycle and then holds fu_result/fu_tag
// stable. The block latches a pending flag, grants one pending FU per cycle
// in round-robin order (only when the FIFO has room), writes the granted
// result at the FIFO tail and pulses fu_queued for that FU one cycle later.
//
// Optional feature (compile-time macro BROADCAST_QUEUE_BYPASS_EN):
//   When defined and the FIFO is empty, a granted result drives the CDB
//   combinationally in its grant cycle. If the consumer takes it that same
//   cycle the entry never enters the FIFO. When undefined there is no
//   combinational path from the fu_* inputs to the cdb_* outputs.

module broadcast_queue #(
    parameter int NUM_FU     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 7,
    parameter int DEPTH      = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_FU-1:0]              fu_done,
    input  logic [NUM_FU*DATA_WIDTH-1:0]   fu_result,
    input  logic [NUM_FU*TAG_WIDTH-1:0]    fu_tag,
    output logic [NUM_FU-1:0]              fu_queued,
    output logic                           cdb_valid,
    output logic [TAG_WIDTH-1:0]           cdb_tag,
    output logic [DATA_WIDTH-1:0]          cdb_data,
    input  logic                           cdb_ready,
    output logic [$clog2(DEPTH):0]         occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = $clog2(NUM_FU);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [RR_W-1:0]  LAST_FU  = RR_W'(NUM_FU - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_FU-1:0]     pending_r;
    logic [NUM_FU-1:0]     fu_queued_r;
    logic [RR_W-1:0]       rr_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [TAG_WIDTH-1:0]  tag_mem_r  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                  fifo_pop_s;
    logic                  space_s;
    logic                  grant_any_s;
    logic [RR_W-1:0]       grant_idx_s;
    logic [NUM_FU-1:0]     grant_vec_s;
    logic [TAG_WIDTH-1:0]  grant_tag_s;
    logic [DATA_WIDTH-1:0] grant_data_s;
    logic                  push_s;
`ifdef BROADCAST_QUEUE_BYPASS_EN
    logic                  bypass_s;
`endif

    // Pop only a real FIFO entry; a room check accounts for a same-cycle pop.
    always_comb begin
        fifo_pop_s = (count_r != {CNT_W{1'b0}}) && cdb_ready;
        space_s    = (count_r != FULL_CNT) || fifo_pop_s;
    end

    // Round-robin search over pending FUs starting at rr_ptr_r.
    always_comb begin
        int idx;
        idx         = 0;
        grant_any_s = 1'b0;
        grant_idx_s = {RR_W{1'b0}};
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(rr_ptr_r) + k;
            if (idx >= NUM_FU) begin
                idx = idx - NUM_FU;
            end else begin
                idx = idx;
            end
            if (!grant_any_s && space_s && pending_r[idx]) begin
                grant_any_s = 1'b1;
                grant_idx_s = RR_W'(idx);
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // One-hot grant vector and the granted FU's result/tag.
    always_comb begin
        grant_vec_s = {NUM_FU{1'b0}};
        for (int i = 0; i < NUM_FU; i++) begin
            if (grant_any_s && (grant_idx_s == RR_W'(i))) begin
                grant_vec_s[i] = 1'b1;
            end else begin
                grant_vec_s[i] = 1'b0;
            end
        end
        grant_tag_s  = fu_tag[int'(grant_idx_s)*TAG_WIDTH +: TAG_WIDTH];
        grant_data_s = fu_result[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef BROADCAST_QUEUE_BYPASS_EN
    // A grant into an empty FIFO is shown directly on the CDB; it is only
    // written to the FIFO if the consumer does not take it this cycle.
    always_comb begin
        bypass_s = (count_r == {CNT_W{1'b0}}) && grant_any_s;
        push_s   = grant_any_s && !(bypass_s && cdb_ready);
    end
`else
    // Every grant is written to the FIFO tail.
    always_comb begin
        push_s = grant_any_s;
    end
`endif

    // CDB drive: FIFO head from storage, optionally overridden by the bypass.
    always_comb begin
        cdb_valid = (count_r != {CNT_W{1'b0}});
        cdb_tag   = tag_mem_r[rd_ptr_r];
        cdb_data  = data_mem_r[rd_ptr_r];
`ifdef BROADCAST_QUEUE_BYPASS_EN
        if (bypass_s) begin
            cdb_valid = 1'b1;
            cdb_tag   = grant_tag_s;
            cdb_data  = grant_data_s;
        end else begin
            cdb_valid = cdb_valid;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Pending flags, acknowledges, arbitration pointer, FIFO pointers/count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r   <= {NUM_FU{1'b0}};
            fu_queued_r <= {NUM_FU{1'b0}};
            rr_ptr_r    <= {RR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
        end else begin
            // A new done wins over a same-cycle clear; a done on an already
            // pending FU just leaves the flag set.
            pending_r   <= (pending_r & ~grant_vec_s) | fu_done;
            fu_queued_r <= grant_vec_s;

            if (grant_any_s) begin
                if (grant_idx_s == LAST_FU) begin
                    rr_ptr_r <= {RR_W{1'b0}};
                end else begin
                    rr_ptr_r <= grant_idx_s + RR_W'(1);
                end
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end

            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end

            if (fifo_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end

            case ({push_s, fifo_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage write at the tail; contents need no reset.
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            tag_mem_r[wr_ptr_r]  <= grant_tag_s;
            data_mem_r[wr_ptr_r] <= grant_data_s;
        end
    end

    assign fu_queued = fu_queued_r;
    assign occupancy = count_r;

endmodule
